// File: rtl/mesh_term_pkg.sv
// Shared types and helpers for the mesh terminal bridge.
// Packet/statistic widths here are the defaults; the bridge itself is parametrised.
package mesh_term_pkg;

  localparam int unsigned PCKG_SZ_DEF = 40;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef logic [PCKG_SZ_DEF-1:0] pckt_t;
  typedef logic [CNT_W_DEF-1:0]   stat_t;

  localparam logic [7:0] BDCST = {8{1'b1}};

  // One terminal per mesh edge position: two rows of columns and two columns of rows.
  function automatic int unsigned nterm(input int unsigned rows, input int unsigned cols);
    return rows * 2 + cols * 2;
  endfunction

endpackage

// File: rtl/mesh_term_bridge_if.sv
// Host/mesh facing signal bundle of the terminal bridge.
// The bridge uses the slave modport; the host/mesh side uses master.
interface mesh_term_bridge_if #(
  parameter int unsigned NTERM   = 16,
  parameter int unsigned PCKG_SZ = 40,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SEL_W   = 4
);

  logic [NTERM-1:0]         push;
  logic [NTERM*PCKG_SZ-1:0] push_data;
  logic [NTERM-1:0]         tx_full;
  logic [NTERM-1:0]         pndng_i_in;
  logic [NTERM*PCKG_SZ-1:0] data_out_i_in;
  logic [NTERM-1:0]         popin;
  logic [NTERM-1:0]         pndng;
  logic [NTERM*PCKG_SZ-1:0] data_out;
  logic [NTERM-1:0]         pop;
  logic [NTERM-1:0]         rx_valid;
  logic [NTERM*PCKG_SZ-1:0] rx_data;
  logic [NTERM-1:0]         rx_ready;
  logic [NTERM-1:0]         ovf_err;
  logic [SEL_W-1:0]         stat_sel;
  logic [CNT_W-1:0]         stat_tx;
  logic [CNT_W-1:0]         stat_rx;
  logic [CNT_W-1:0]         stat_drop;

  modport master (
    output push, push_data, popin, pndng, data_out, rx_ready, stat_sel,
    input  tx_full, pndng_i_in, data_out_i_in, pop, rx_valid, rx_data, ovf_err,
    input  stat_tx, stat_rx, stat_drop
  );

  modport slave (
    input  push, push_data, popin, pndng, data_out, rx_ready, stat_sel,
    output tx_full, pndng_i_in, data_out_i_in, pop, rx_valid, rx_data, ovf_err,
    output stat_tx, stat_rx, stat_drop
  );

endinterface

// File: rtl/mesh_term_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers.
// A push while full is still accepted when the same cycle pops a word.
module mesh_term_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q[AW-1:0]];
  assign count   = wptr_q - rptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage is not reset; the head simply shows stale content while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mesh_term_bridge.sv
// Per-terminal TX/RX buffering between host logic and mesh router terminal ports.
// Define MESH_TERM_STATS_EN to build per-terminal saturating tx/rx/drop counters.
module mesh_term_bridge
  import mesh_term_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned PCKG_SZ    = PCKG_SZ_DEF,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mesh_term_bridge_if.slave bus
);

  localparam int unsigned NTERM = nterm(ROWS, COLUMS);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

`ifdef MESH_TERM_STATS_EN
  logic [CNT_W-1:0] tx_cnt   [NTERM];
  logic [CNT_W-1:0] rx_cnt   [NTERM];
  logic [CNT_W-1:0] drop_cnt [NTERM];
`endif

  for (genvar i = 0; i < NTERM; i++) begin : g_term
    logic               tx_full, tx_empty, rx_full, rx_empty, tx_drop, rx_take, ovf_q;
    logic [PCKG_SZ-1:0] tx_head, rx_head;
    logic [CW-1:0]      tx_count, rx_count;

    mesh_term_fifo #(
      .Width (PCKG_SZ),
      .Depth (FIFO_DEPTH)
    ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.push[i]),
      .pop   (bus.popin[i]),
      .wdata (bus.push_data[i*PCKG_SZ +: PCKG_SZ]),
      .full  (tx_full),
      .empty (tx_empty),
      .head  (tx_head),
      .count (tx_count)
    );

    // Backpressure ignores a same-cycle rx_ready, leaving a one-cycle bubble at full.
    assign rx_take = bus.pndng[i] & ~rx_full & ~reset;

    mesh_term_fifo #(
      .Width (PCKG_SZ),
      .Depth (FIFO_DEPTH)
    ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_take),
      .pop   (bus.rx_ready[i]),
      .wdata (bus.data_out[i*PCKG_SZ +: PCKG_SZ]),
      .full  (rx_full),
      .empty (rx_empty),
      .head  (rx_head),
      .count (rx_count)
    );

    assign bus.tx_full[i]                             = tx_full;
    assign bus.pndng_i_in[i]                          = ~tx_empty;
    assign bus.data_out_i_in[i*PCKG_SZ +: PCKG_SZ]    = tx_head;
    assign bus.pop[i]                                 = rx_take;
    assign bus.rx_valid[i]                            = ~rx_empty;
    assign bus.rx_data[i*PCKG_SZ +: PCKG_SZ]          = rx_head;
    assign bus.ovf_err[i]                             = ovf_q;

    // Full implies non-empty, so popin alone frees a slot for the push.
    assign tx_drop = bus.push[i] & tx_full & ~bus.popin[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset)        ovf_q <= 1'b0;
      else if (tx_drop) ovf_q <= 1'b1;
    end

    assert property (@(posedge clk) disable iff (reset)
      (32'(tx_count) <= FIFO_DEPTH) && (32'(rx_count) <= FIFO_DEPTH));

`ifdef MESH_TERM_STATS_EN
    logic             tx_acc;
    logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q, drop_cnt_q;

    assign tx_acc = bus.push[i] & (~tx_full | bus.popin[i]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tx_cnt_q   <= '0;
        rx_cnt_q   <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (tx_acc  && tx_cnt_q   != '1) tx_cnt_q   <= tx_cnt_q   + CNT_W'(1);
        if (rx_take && rx_cnt_q   != '1) rx_cnt_q   <= rx_cnt_q   + CNT_W'(1);
        if (tx_drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end

    assign tx_cnt[i]   = tx_cnt_q;
    assign rx_cnt[i]   = rx_cnt_q;
    assign drop_cnt[i] = drop_cnt_q;
`endif
  end

`ifdef MESH_TERM_STATS_EN
  always_comb begin
    bus.stat_tx   = '0;
    bus.stat_rx   = '0;
    bus.stat_drop = '0;
    if (32'(bus.stat_sel) < NTERM) begin
      bus.stat_tx   = tx_cnt[bus.stat_sel];
      bus.stat_rx   = rx_cnt[bus.stat_sel];
      bus.stat_drop = drop_cnt[bus.stat_sel];
    end
  end
`else
  assign bus.stat_tx   = '0;
  assign bus.stat_rx   = '0;
  assign bus.stat_drop = '0;
`endif

endmodule

// File: tb/tb_mesh_term_bridge.sv
// Randomised and directed bench for mesh_term_bridge against a queue-based reference model.
// Stat expectations follow MESH_TERM_STATS_EN.
module tb_mesh_term_bridge;
  import mesh_term_pkg::*;

  localparam int unsigned ROWS       = 3;
  localparam int unsigned COLUMS     = 4;
  localparam int unsigned NTERM      = nterm(ROWS, COLUMS);
  localparam int unsigned PCKG_SZ    = 40;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SEL_W      = $clog2(NTERM);
`ifdef MESH_TERM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [PCKG_SZ-1:0] word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mesh_term_bridge_if #(
    .NTERM   (NTERM),
    .PCKG_SZ (PCKG_SZ),
    .CNT_W   (CNT_W),
    .SEL_W   (SEL_W)
  ) bus ();

  mesh_term_bridge #(
    .ROWS       (ROWS),
    .COLUMS     (COLUMS),
    .PCKG_SZ    (PCKG_SZ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per FIFO plus event counts.
  word_t txq [NTERM][$];
  word_t rxq [NTERM][$];
  bit    ovf_m  [NTERM];
  int    tx_n   [NTERM];
  int    rx_n   [NTERM];
  int    drop_n [NTERM];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int v);
    int mx;
    mx = (1 << CNT_W) - 1;
    return 64'((v > mx) ? mx : v);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NTERM; t++) begin
      txq[t].delete();
      rxq[t].delete();
      ovf_m[t]  = 1'b0;
      tx_n[t]   = 0;
      rx_n[t]   = 0;
      drop_n[t] = 0;
    end
  endtask

  // Applies the current inputs to the model as the next clock edge will.
  task automatic model_step();
    for (int t = 0; t < NTERM; t++) begin
      bit tpop, acc, rpop, cap;
      tpop = bus.popin[t] && (txq[t].size() > 0);
      acc  = bus.push[t] && ((txq[t].size() < FIFO_DEPTH) || tpop);
      if (tpop) void'(txq[t].pop_front());
      if (acc) begin
        txq[t].push_back(bus.push_data[t*PCKG_SZ +: PCKG_SZ]);
        tx_n[t]++;
      end
      if (bus.push[t] && !acc) begin
        ovf_m[t] = 1'b1;
        drop_n[t]++;
      end
      rpop = bus.rx_ready[t] && (rxq[t].size() > 0);
      cap  = bus.pndng[t] && (rxq[t].size() < FIFO_DEPTH);
      if (rpop) void'(rxq[t].pop_front());
      if (cap) begin
        rxq[t].push_back(bus.data_out[t*PCKG_SZ +: PCKG_SZ]);
        rx_n[t]++;
      end
    end
  endtask

  task automatic check_all();
    int s;
    for (int t = 0; t < NTERM; t++) begin
      check($sformatf("pndng_i_in[%0d]", t), 64'(bus.pndng_i_in[t]), 64'(txq[t].size() != 0));
      check($sformatf("tx_full[%0d]", t), 64'(bus.tx_full[t]),
            64'(txq[t].size() == FIFO_DEPTH));
      if (txq[t].size() != 0)
        check($sformatf("tx_head[%0d]", t), 64'(bus.data_out_i_in[t*PCKG_SZ +: PCKG_SZ]),
              64'(txq[t][0]));
      check($sformatf("rx_valid[%0d]", t), 64'(bus.rx_valid[t]), 64'(rxq[t].size() != 0));
      if (rxq[t].size() != 0)
        check($sformatf("rx_data[%0d]", t), 64'(bus.rx_data[t*PCKG_SZ +: PCKG_SZ]),
              64'(rxq[t][0]));
      check($sformatf("pop[%0d]", t), 64'(bus.pop[t]),
            64'(bus.pndng[t] && (rxq[t].size() < FIFO_DEPTH)));
      check($sformatf("ovf_err[%0d]", t), 64'(bus.ovf_err[t]), 64'(ovf_m[t]));
    end
    s = int'(bus.stat_sel);
    check("stat_tx",   64'(bus.stat_tx),   (STATS && s < NTERM) ? sat(tx_n[s])   : 64'd0);
    check("stat_rx",   64'(bus.stat_rx),   (STATS && s < NTERM) ? sat(rx_n[s])   : 64'd0);
    check("stat_drop", 64'(bus.stat_drop), (STATS && s < NTERM) ? sat(drop_n[s]) : 64'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    bus.push     = '0;
    bus.push_data = '0;
    bus.popin    = '0;
    bus.pndng    = '0;
    bus.data_out = '0;
    bus.rx_ready = '0;
  endtask

  task automatic set_push(input int t, input word_t w);
    bus.push[t] = 1'b1;
    bus.push_data[t*PCKG_SZ +: PCKG_SZ] = w;
  endtask

  function automatic word_t rand_word();
    return word_t'({$urandom(), $urandom()});
  endfunction

  initial begin
    int pp, pq;
    reset = 1'b1;
    idle();
    bus.stat_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pndng", 64'(bus.pndng_i_in), 64'd0);
    check("reset_rx_valid", 64'(bus.rx_valid), 64'd0);
    reset = 1'b0;
    #1 check_all();

    // Reset mid-stream flushes immediately, before any clock edge.
    for (int k = 1; k <= 2; k++) begin
      idle();
      set_push(0, word_t'(k));
      tick();
    end
    set_push(0, word_t'(3));
    bus.pndng[0] = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rst_pndng0", 64'(bus.pndng_i_in[0]), 64'd0);
    check("rst_tx_full", 64'(bus.tx_full), 64'd0);
    check("rst_ovf", 64'(bus.ovf_err), 64'd0);
    check("rst_pop", 64'(bus.pop), 64'd0);
    idle();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 check_all();
    @(negedge clk);

    // TX ordering and latency on terminal 5.
    idle();
    bus.popin[5] = 1'b1;
    set_push(5, word_t'('hA1));
    tick();
    check("t5_pndng_rise", 64'(bus.pndng_i_in[5]), 64'd1);
    check("t5_head_a1", 64'(bus.data_out_i_in[5*PCKG_SZ +: PCKG_SZ]), 64'hA1);
    set_push(5, word_t'('hA2));
    tick();
    check("t5_head_a2", 64'(bus.data_out_i_in[5*PCKG_SZ +: PCKG_SZ]), 64'hA2);
    bus.push[5] = 1'b0;
    tick();
    check("t5_drained", 64'(bus.pndng_i_in[5]), 64'd0);

    // Overflow on terminal 3.
    idle();
    bus.stat_sel = SEL_W'(3);
    for (int k = 1; k <= 9; k++) begin
      set_push(3, word_t'(k));
      tick();
      if (k == 8) check("t3_full_after8", 64'(bus.tx_full[3]), 64'd1);
    end
    check("t3_ovf", 64'(bus.ovf_err[3]), 64'd1);
    check("t3_drop", 64'(bus.stat_drop), STATS ? 64'd1 : 64'd0);
    idle();
    bus.popin[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t3_word%0d", k), 64'(bus.data_out_i_in[3*PCKG_SZ +: PCKG_SZ]), 64'(k));
      tick();
    end

    // Full with simultaneous popin and push on terminal 4.
    idle();
    for (int k = 0; k < 8; k++) begin
      set_push(4, word_t'('h10 + k));
      tick();
    end
    bus.popin[4] = 1'b1;
    set_push(4, word_t'('h55));
    tick();
    check("t4_still_full", 64'(bus.tx_full[4]), 64'd1);
    check("t4_no_ovf", 64'(bus.ovf_err[4]), 64'd0);
    bus.push[4] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("t4_last", 64'(bus.data_out_i_in[4*PCKG_SZ +: PCKG_SZ]), 64'h55);
    tick();

    // RX backpressure on terminal 2.
    idle();
    bus.stat_sel = SEL_W'(2);
    bus.pndng[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.data_out[2*PCKG_SZ +: PCKG_SZ] = rand_word();
      #1 check($sformatf("t2_pop_c%0d", k), 64'(bus.pop[2]), 64'(k < 8));
      tick();
    end
    bus.rx_ready[2] = 1'b1;
    tick();
    bus.rx_ready[2] = 1'b0;
    #1 check("t2_pop_resume", 64'(bus.pop[2]), 64'd1);
    tick();
    check("t2_stat_rx", 64'(bus.stat_rx), STATS ? 64'd9 : 64'd0);
    bus.pndng[2]    = 1'b0;
    bus.rx_ready[2] = 1'b1;
    for (int k = 0; k < 9; k++) tick();

    // Counter saturation on terminal 1.
    idle();
    bus.stat_sel = SEL_W'(1);
    bus.popin[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_push(1, rand_word());
      tick();
    end
    check("t1_stat_sat", 64'(bus.stat_tx), STATS ? 64'd15 : 64'd0);
    idle();
    bus.stat_sel = SEL_W'(NTERM);
    #1;
    check("sel_oob_tx", 64'(bus.stat_tx), 64'd0);
    check("sel_oob_rx", 64'(bus.stat_rx), 64'd0);
    check("sel_oob_drop", 64'(bus.stat_drop), 64'd0);
    tick();

    // Random traffic across all terminals with varying load mixes.
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       begin pp = 70; pq = 25; end
        1:       begin pp = 25; pq = 75; end
        2:       begin pp = 90; pq = 90; end
        default: begin pp = 50; pq = 50; end
      endcase
      for (int c = 0; c < 150; c++) begin
        for (int t = 0; t < NTERM; t++) begin
          bus.push[t]     = ($urandom_range(0, 99) < pp);
          bus.push_data[t*PCKG_SZ +: PCKG_SZ] = rand_word();
          bus.popin[t]    = ($urandom_range(0, 99) < pq);
          bus.pndng[t]    = ($urandom_range(0, 99) < pp);
          bus.data_out[t*PCKG_SZ +: PCKG_SZ] = rand_word();
          bus.rx_ready[t] = ($urandom_range(0, 99) < pq);
        end
        bus.stat_sel = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_term_bridge.md
Name: mesh_term_bridge

Overview:
- Per-terminal buffering bridge between test/host logic and the mesh router's terminal ports.
- Supports NTERM = ROWS*2+COLUMS*2 terminals.
- Each terminal has:
  - a TX FIFO that drives the mesh pending/pop-in handshake;
  - an RX FIFO that drains the mesh output handshake.
- Generalises the fixed-size terminal interface to parametrised depth and width, and adds overflow detection and backpressure.

Parameters:
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- NTERM, ROWS*2+COLUMS*2, number of terminals (derived; do not override).
- PCKG_SZ, 40, packet width in bits.
- FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- push  in  NTERM  host write strobe per terminal.
- push_data  in  NTERM*PCKG_SZ  host write data; terminal i occupies bits [i*PCKG_SZ +: PCKG_SZ].
- tx_full  out  NTERM  TX FIFO full.
- pndng_i_in  out  NTERM  TX FIFO not empty, presented to mesh.
- data_out_i_in  out  NTERM*PCKG_SZ  TX FIFO head word.
- popin  in  NTERM  mesh consumes TX head.
- pndng  in  NTERM  mesh has an output packet pending.
- data_out  in  NTERM*PCKG_SZ  mesh output packet.
- pop  out  NTERM  bridge accepts mesh output.
- rx_valid  out  NTERM  RX FIFO not empty.
- rx_data  out  NTERM*PCKG_SZ  RX FIFO head word.
- rx_ready  in  NTERM  host consumes RX head.
- ovf_err  out  NTERM  sticky TX overflow flag.
- stat_sel  in  $clog2(NTERM)  statistics channel select.
- stat_tx, stat_rx, stat_drop  out  CNT_W each  statistics for the selected channel.

Behaviour:
- Reset:
  - Asynchronous, active-high. Assertion at any time, including mid-transfer, flushes every FIFO and clears pointers, counts, ovf_err and counters.
  - While in reset: tx_full=0, pndng_i_in=0, rx_valid=0, pop=0, ovf_err=0.
- FIFO implementation:
  - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit.
  - full: pointers equal except for the MSB. empty: pointers fully equal.
  - Head is first-word fall-through.
- TX path (per terminal i):
  - push with !tx_full writes at the clock edge.
  - Latency: push at edge N gives pndng_i_in high and valid data_out_i_in after edge N.
  - push while full and popin high in the same cycle: the write is accepted. Count stays at FIFO_DEPTH.
  - push while full without popin: the word is dropped, ovf_err[i] is set (sticky until reset), and the drop is counted.
  - popin while pndng_i_in high advances the read pointer.
  - popin while empty is ignored. This holds even if push is simultaneous; the pushed word is stored.
  - data_out_i_in is don't-care while empty but stable, and holds the last RAM content.
- RX path (per terminal i):
  - pop[i] = pndng[i] & !rx_full[i], combinational. data_out[i] is captured at the same edge.
  - rx_full does not account for a simultaneous rx_ready. This gives a deliberate one-cycle bubble at full.
  - rx_ready while rx_valid high advances the read pointer. rx_ready while empty is ignored.
  - Simultaneous capture and rx_ready on a non-full, non-empty FIFO: count is unchanged.
- Terminals are fully independent; there is no arbitration between channels.
- All flags are derived from registered pointers. No outputs are registered beyond the FIFO state.

Optional Feature:
- Macro: MESH_TERM_STATS_EN.
- With the macro defined, per-terminal CNT_W-bit saturating counters:
  - tx: accepted pushes;
  - rx: pop handshakes;
  - drop: rejected pushes.
- Counters saturate at all-ones and never wrap.
- stat_* outputs show the counters of terminal stat_sel, combinationally.
- stat_sel >= NTERM returns 0.
- Without the macro: no counter flops are built, stat_* are tied to 0, and ovf_err still works.

Decomposition:
- Package mesh_term_pkg holds:
  - pckt_t (logic [PCKG_SZ-1:0]);
  - NTERM derivation function;
  - BDCST constant {8{1'b1}};
  - stat_t typedef (CNT_W).
- One sub-module, mesh_term_fifo:
  - parametrised FIFO with push/pop/full/empty/head/count;
  - instantiated 2*NTERM times via generate.

Test Plan:
- Reset flush: push 3 words on terminal 0, assert reset mid-stream -> pndng_i_in[0]=0, tx_full=0, ovf_err=0 immediately, before the clock.
- TX ordering/latency: push 0xA1, 0xA2 on terminal 5 on consecutive edges, popin held high -> data_out_i_in[5] shows 0xA1 then 0xA2 on successive cycles; pndng_i_in[5] rises one cycle after the first push.
- Overflow: with FIFO_DEPTH=8, 9 pushes without popin -> tx_full after the 8th; the 9th is dropped, ovf_err[i]=1, stat_drop=1 (STATS_EN); then 8 popins return words 1..8.
- Full plus simultaneous popin and push: FIFO full, push 0x55 with popin -> accepted, tx_full stays 1, ovf_err stays 0; 0x55 emerges last.
- RX backpressure: pndng[2] held high with rx_ready=0 -> pop[2] high for 8 cycles then 0. One rx_ready pulse -> pop[2] re-asserts the following cycle; stat_rx=9.
- Saturation (STATS_EN, CNT_W=4): 20 accepted pushes on terminal 1 with popin high -> stat_tx=15 when stat_sel=1; stat_sel=NTERM returns 0.
